// File: rtl/spi_slave_pkg.sv
// Shared constants for the SPI slave: mode encoding, idle MISO level and byte framing.
package spi_slave_pkg;

    typedef enum logic [1:0] {
        MODE0 = 2'd0,
        MODE1 = 2'd1,
        MODE2 = 2'd2,
        MODE3 = 2'd3
    } spi_mode_e;

    localparam logic        IDLE_MISO = 1'b1;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned CNT_W     = $clog2(BYTE_W);

    function automatic logic mode_cpol(spi_mode_e m);
        return (m == MODE2) || (m == MODE3);
    endfunction

    function automatic logic mode_cpha(spi_mode_e m);
        return (m == MODE1) || (m == MODE3);
    endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Two-flop synchroniser for an asynchronous input, followed by a rising/falling edge detector.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic fpga_clk,
    input  logic rst,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    // Resynchronise the input and keep one extra stage for edge comparison
    always_ff @(posedge fpga_clk) begin
        if (rst) begin
            meta <= RST_VAL;
            sync <= RST_VAL;
            prev <= RST_VAL;
        end else begin
            meta <= async_in;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/spi_slave.sv
// Byte-oriented SPI slave running entirely in the system clock domain.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int SPI_MODE = 0
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    output logic              o_RX_DV,
    output logic [BYTE_W-1:0] o_RX_Byte,
    input  logic              i_TX_DV,
    input  logic [BYTE_W-1:0] i_TX_Byte,
    input  logic              i_SPI_Clk,
    output logic              o_SPI_MISO,
    input  logic              i_SPI_MOSI,
    input  logic              i_SPI_CS_n
);

    localparam spi_mode_e        MODE     = spi_mode_e'(SPI_MODE[1:0]);
    localparam logic             CPOL     = mode_cpol(MODE);
    localparam logic             CPHA     = mode_cpha(MODE);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BYTE_W - 1);

    logic              sck_rise;
    logic              sck_fall;
    logic              cs_rise;
    logic              cs_fall;
    logic              sample_edge;
    logic              shift_edge;
    logic              mosi_meta;
    logic              mosi_sync;
    logic              cs_active;
    logic [CNT_W-1:0]  bit_cnt;
    logic [BYTE_W-1:0] rx_shift;
    logic              rx_done;
    logic [BYTE_W-1:0] tx_hold;
    logic [BYTE_W-1:0] tx_shift;

    spi_sync_edge #(.RST_VAL(CPOL)) u_sck_sync (
        .fpga_clk (i_Clk),
        .rst      (i_Rst),
        .async_in (i_SPI_Clk),
        .rise     (sck_rise),
        .fall     (sck_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
        .fpga_clk (i_Clk),
        .rst      (i_Rst),
        .async_in (i_SPI_CS_n),
        .rise     (cs_rise),
        .fall     (cs_fall)
    );

    // Sample edge is the leading edge for CPHA=0 and the trailing edge for CPHA=1
    assign sample_edge = (CPOL ^ CPHA) ? sck_fall : sck_rise;
    assign shift_edge  = (CPOL ^ CPHA) ? sck_rise : sck_fall;

    // MOSI goes through the same two-flop delay as SCK so data and edge stay aligned
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            mosi_meta <= i_SPI_MOSI;
            mosi_sync <= mosi_meta;
        end
    end

    // Frame tracking, bit counter, RX/TX shift registers and the TX holding register
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            cs_active <= 1'b0;
            bit_cnt   <= '0;
            rx_shift  <= '0;
            rx_done   <= 1'b0;
            tx_hold   <= '0;
            tx_shift  <= '0;
        end else begin
            rx_done <= 1'b0;
            if (i_TX_DV) begin
                tx_hold <= i_TX_Byte;
            end
            if (cs_fall) begin
                cs_active <= 1'b1;
                bit_cnt   <= '0;
            end
            if (cs_rise) begin
                cs_active <= 1'b0;
                bit_cnt   <= '0;
                tx_shift  <= '0;
            end else if (cs_active) begin
                if (sample_edge) begin
                    rx_shift <= {rx_shift[BYTE_W-2:0], mosi_sync};
                    bit_cnt  <= bit_cnt + 1'b1;
                    // Latch point: a TX_DV in the same cycle wins the holding register
                    if (bit_cnt == '0) begin
                        tx_shift <= tx_hold;
                        if (!i_TX_DV) begin
                            tx_hold <= '0;
                        end
                    end
                    if (bit_cnt == LAST_BIT) begin
                        rx_done <= 1'b1;
                    end
                end else if (shift_edge && (bit_cnt != '0)) begin
                    tx_shift <= {tx_shift[BYTE_W-2:0], 1'b0};
                end
            end
        end
    end

    // Publish a completed byte with a one-cycle strobe
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            o_RX_DV   <= 1'b0;
            o_RX_Byte <= '0;
        end else begin
            o_RX_DV <= rx_done;
            if (rx_done) begin
                o_RX_Byte <= rx_shift;
            end
        end
    end

    // Between bytes the holding MSB is driven directly, so it is valid before any shift edge
    always_comb begin
        o_SPI_MISO = IDLE_MISO;
        if (cs_active) begin
            o_SPI_MISO = (bit_cnt == '0) ? tx_hold[BYTE_W-1] : tx_shift[BYTE_W-1];
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: a mode-0 and a mode-3 instance driven by a behavioural SPI master.
module tb_spi_slave;

    localparam int HP = 8;  // SPI half period in system clocks

    logic       clk = 1'b0;
    logic       rst;
    logic       sck;
    logic       mosi;
    logic       cs0_n;
    logic       cs3_n;
    logic       tx_dv0;
    logic       tx_dv3;
    logic [7:0] tx_byte;
    logic       rx_dv0;
    logic       rx_dv3;
    logic [7:0] rx_byte0;
    logic [7:0] rx_byte3;
    logic       miso0;
    logic       miso3;

    always #5 clk = ~clk;

    spi_slave #(.SPI_MODE(0)) dut0 (
        .i_Clk      (clk),
        .i_Rst      (rst),
        .o_RX_DV    (rx_dv0),
        .o_RX_Byte  (rx_byte0),
        .i_TX_DV    (tx_dv0),
        .i_TX_Byte  (tx_byte),
        .i_SPI_Clk  (sck),
        .o_SPI_MISO (miso0),
        .i_SPI_MOSI (mosi),
        .i_SPI_CS_n (cs0_n)
    );

    spi_slave #(.SPI_MODE(3)) dut3 (
        .i_Clk      (clk),
        .i_Rst      (rst),
        .o_RX_DV    (rx_dv3),
        .o_RX_Byte  (rx_byte3),
        .i_TX_DV    (tx_dv3),
        .i_TX_Byte  (tx_byte),
        .i_SPI_Clk  (sck),
        .o_SPI_MISO (miso3),
        .i_SPI_MOSI (mosi),
        .i_SPI_CS_n (cs3_n)
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] rx_q0[$];
    logic [7:0] rx_q3[$];
    logic [7:0] hold_model[4];  // reference TX holding register, indexed by mode
    logic [7:0] fb[4];          // bytes the master sends in the next frame

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic int qsize(input int sel);
        return (sel == 0) ? rx_q0.size() : rx_q3.size();
    endfunction

    function automatic logic miso_of(input int sel);
        return (sel == 0) ? miso0 : miso3;
    endfunction

    task automatic half();
        repeat (HP) @(negedge clk);
    endtask

    task automatic set_cs(input int sel, input logic v);
        if (sel == 0) cs0_n = v;
        else cs3_n = v;
    endtask

    task automatic load_tx(input int sel, input logic [7:0] b);
        @(negedge clk);
        tx_byte = b;
        if (sel == 0) tx_dv0 = 1'b1;
        else tx_dv3 = 1'b1;
        @(negedge clk);
        tx_dv0 = 1'b0;
        tx_dv3 = 1'b0;
        hold_model[sel] = b;
    endtask

    // One byte (or its first nbits) as an SPI master of the instance's mode
    task automatic spi_byte(input int sel, input logic [7:0] tx_b, output logic [7:0] rx_b,
                            input int nbits);
        logic cpol;
        logic cpha;
        cpol = (sel == 3);
        cpha = (sel == 3);
        rx_b = '0;
        for (int i = 7; i >= 8 - nbits; i--) begin
            if (!cpha) begin
                mosi = tx_b[i];
                half();
                sck = ~cpol;
                rx_b[i] = miso_of(sel);
                half();
                sck = cpol;
            end else begin
                sck = ~cpol;
                mosi = tx_b[i];
                half();
                sck = cpol;
                rx_b[i] = miso_of(sel);
                half();
            end
        end
    endtask

    task automatic wait_drain(input int sel);
        for (int k = 0; k < 60 && qsize(sel) != 0; k++) @(negedge clk);
        check($sformatf("rx_drain_m%0d", sel), qsize(sel), 0);
    endtask

    // One CS-low frame of n bytes; the last one is cut short when last_bits < 8
    task automatic frame(input int sel, input int n, input int last_bits);
        logic [7:0] got;
        logic [7:0] exp_b;
        int         bits;
        sck = (sel == 3);
        half();
        set_cs(sel, 1'b0);
        half();
        for (int k = 0; k < n; k++) begin
            bits = (k == n - 1) ? last_bits : 8;
            exp_b = hold_model[sel];
            hold_model[sel] = 8'h00;
            if (bits == 8) begin
                if (sel == 0) rx_q0.push_back(fb[k]);
                else rx_q3.push_back(fb[k]);
            end
            spi_byte(sel, fb[k], got, bits);
            if (bits == 8) check($sformatf("miso_byte_m%0d", sel), got, exp_b);
        end
        half();
        set_cs(sel, 1'b1);
        half();
        wait_drain(sel);
    endtask

    // RX monitors: every strobe must match the oldest outstanding byte
    always @(negedge clk) begin
        if (rx_dv0 === 1'b1) begin
            check("rx_dv_expected_m0", rx_q0.size() != 0, 1);
            if (rx_q0.size() != 0) check("rx_byte_m0", rx_byte0, rx_q0.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rx_dv3 === 1'b1) begin
            check("rx_dv_expected_m3", rx_q3.size() != 0, 1);
            if (rx_q3.size() != 0) check("rx_byte_m3", rx_byte3, rx_q3.pop_front());
        end
    end

    initial begin
        #1500000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] junk;
        int         sel;
        int         n;
        int         lb;
        rst = 1'b1;
        sck = 1'b0;
        mosi = 1'b0;
        cs0_n = 1'b1;
        cs3_n = 1'b1;
        tx_dv0 = 1'b0;
        tx_dv3 = 1'b0;
        tx_byte = 8'h00;
        for (int i = 0; i < 4; i++) hold_model[i] = 8'h00;
        repeat (4) @(negedge clk);
        check("reset_rx_dv_m0", rx_dv0, 0);
        check("reset_rx_byte_m0", rx_byte0, 0);
        check("reset_miso_m0", miso0, 1);
        check("reset_miso_m3", miso3, 1);
        check("reset_rx_byte_m3", rx_byte3, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        fb[0] = 8'hAA;
        frame(0, 1, 8);

        load_tx(0, 8'h5A);
        fb[0] = 8'h99;
        frame(0, 1, 8);

        load_tx(0, 8'h12);
        fb[0] = 8'h66; fb[1] = 8'h00; fb[2] = 8'hFF;
        frame(0, 3, 8);

        load_tx(0, 8'h3C);
        fb[0] = 8'hC3;
        frame(0, 1, 5);
        fb[0] = 8'h55;
        frame(0, 1, 8);

        load_tx(3, 8'hC3);
        fb[0] = 8'hE3;
        frame(3, 1, 8);

        // Reset in the middle of a byte
        load_tx(0, 8'hF0);
        load_tx(3, 8'h0F);
        sck = 1'b0;
        half();
        cs0_n = 1'b0;
        half();
        spi_byte(0, 8'h3F, junk, 4);
        hold_model[0] = 8'h00;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_rx_dv_m0", rx_dv0, 0);
        check("midreset_rx_byte_m0", rx_byte0, 0);
        check("midreset_miso_m0", miso0, 1);
        check("midreset_rx_byte_m3", rx_byte3, 0);
        cs0_n = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        hold_model[0] = 8'h00;
        hold_model[3] = 8'h00;
        repeat (4) @(negedge clk);
        fb[0] = 8'h77;
        frame(0, 1, 8);
        fb[0] = 8'h81;
        frame(3, 1, 8);

        for (int it = 0; it < 30; it++) begin
            sel = ($urandom_range(0, 1) == 0) ? 0 : 3;
            n = $urandom_range(1, 3);
            lb = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 8;
            if ($urandom_range(0, 1) == 1) load_tx(sel, 8'($urandom));
            for (int k = 0; k < 4; k++) fb[k] = 8'($urandom);
            frame(sel, n, lb);
        end

        repeat (20) @(negedge clk);
        check("final_queue_m0", rx_q0.size(), 0);
        check("final_queue_m3", rx_q3.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- Byte-oriented SPI slave (target) that converts serial MOSI traffic into parallel bytes and serialises a parallel byte onto MISO.
- Runs entirely in the system clock domain: the SPI clock, chip-select and MOSI are synchronised and edge-detected, not used as clocks.
- Serves as the host-command link for the diagnostics/ROM-replacement controller, which exchanges one byte per command/data step with an external SPI master.

Parameters:
- SPI_MODE, 0, SPI mode 0..3 (CPOL = SPI_MODE[1], CPHA = SPI_MODE[0]).

Ports:
- i_Clk  input  1  system clock; all logic is synchronous to its rising edge.
- i_Rst  input  1  synchronous, active-high reset.
- o_RX_DV  output  1  one-cycle strobe: o_RX_Byte holds a complete received byte.
- o_RX_Byte  output  8  last received byte; held until the next strobe.
- i_TX_DV  input  1  one-cycle strobe: load i_TX_Byte as the next byte to transmit.
- i_TX_Byte  input  8  byte to transmit.
- i_SPI_Clk  input  1  SPI serial clock from master (asynchronous).
- o_SPI_MISO  output  1  serial data to master.
- i_SPI_MOSI  input  1  serial data from master (asynchronous).
- i_SPI_CS_n  input  1  active-low chip select (asynchronous).

Behaviour:
- Clock requirement: the i_Clk frequency must be at least 4x the SPI clock frequency.
- Synchronisation: i_SPI_Clk, i_SPI_MOSI and i_SPI_CS_n each pass through a 2-flop synchroniser.
- Edge detection: edges are detected on the synchronised clock.
  - Leading edge = rising edge if CPOL=0, falling edge if CPOL=1.
  - Sample edge = leading edge if CPHA=0, trailing edge if CPHA=1.
  - Shift edge = the opposite edge to the sample edge.
- Reset values: o_RX_DV=0, o_RX_Byte=0x00, o_SPI_MISO=1, TX holding register=0x00, shift registers=0, bit counter=0.
- Framing: MSB first, 8 bits per byte, back-to-back bytes allowed within one CS-low frame. The bit counter is 3 bits and wraps 7→0 after each byte.
- RX path:
  - On each sample edge while CS is low, shift the synchronised MOSI into the RX shift register.
  - On the 8th sample edge, o_RX_Byte takes the full byte, and o_RX_DV is high for exactly one i_Clk cycle, two i_Clk cycles after the synchronised edge is seen.
  - Worst case, o_RX_DV asserts within 4 i_Clk cycles of the raw SPI edge.
- TX holding register:
  - When i_TX_DV=1, the holding register takes i_TX_Byte in that cycle, regardless of SPI activity.
  - A later i_TX_DV before the byte starts overwrites the earlier value.
- TX latch:
  - The byte in the holding register is copied into the TX shift register at the first sample edge of a byte (bit counter = 0). That is the latch point.
  - After the latch, the holding register clears to 0x00, so an unreloaded byte transmits as 0x00.
- MISO output:
  - CS high: MISO = 1.
  - CS low and bit counter = 0, before the first shift edge of that byte: MISO = holding[7], so mode-0 MSB is valid before the first rising edge.
  - Otherwise MISO = current MSB of the TX shift register, advanced one bit on each shift edge.
  - For CPHA=1, the first shift edge (leading) presents holding[7].
- CS deassert mid-byte: the bit counter resets to 0 and the partial RX byte is discarded (no o_RX_DV). The TX shift register is discarded; the holding register is kept.
- Simultaneous i_TX_DV and latch point in the same cycle: the new i_TX_Byte is written to the holding register and is not latched into the shift register.
- SPI edges while CS is high are ignored.
- i_Rst asserted mid-byte returns everything to reset values on the next i_Clk edge.

Decomposition:
- Shared package: SPI mode encoding constants (MODE0..MODE3), default idle MISO level (1), and byte width (8).
- One sub-module: spi_sync_edge — 2-flop synchroniser plus rising/falling-edge detector, instantiated for the SPI clock and CS. MOSI uses the synchroniser only.

Test Plan:
- Reset, then mode 0: master sends 0xAA with CS low -> exactly one o_RX_DV pulse, o_RX_Byte=0xAA.
- Pulse i_TX_DV with 0x5A while CS is high, then master clocks one byte while sending 0x99 -> master reads 0x5A, slave reports 0x99.
- Three back-to-back bytes 0x66, 0x00, 0xFF in one CS frame, with no TX reload after the first byte (loaded 0x12) -> master reads 0x12, 0x00, 0x00; three o_RX_DV pulses with the correct bytes.
- CS raised after 5 bits, then a full byte 0x55 sent -> no o_RX_DV for the partial byte; the next o_RX_DV carries 0x55.
- SPI_MODE=3, master exchanges 0xE3 with loaded TX 0xC3 -> o_RX_Byte=0xE3, master reads 0xC3.
- i_Rst asserted after 4 bits -> outputs return to reset values; a subsequent full byte 0x77 is received correctly.
